// File: rtl/cpu_pkg.sv
// Shared ISA constants, FSM encodings and instruction-field helpers for the 8-bit core.
package cpu_pkg;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;
  localparam logic [1:0] OP_JUMP  = 2'b11;

  localparam int unsigned SEXT_W = 16;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_ERROR  = 3'd7
  } state_e;

  typedef enum logic [1:0] {
    PC_HOLD = 2'd0,
    PC_INC  = 2'd1,
    PC_REL  = 2'd2
  } pc_sel_e;

  function automatic logic [1:0] op_of(input logic [7:0] i);
    return i[7:6];
  endfunction

  function automatic logic [1:0] rs_of(input logic [7:0] i);
    return i[5:4];
  endfunction

  function automatic logic [1:0] rt_of(input logic [7:0] i);
    return i[3:2];
  endfunction

  function automatic logic [1:0] f_of(input logic [7:0] i);
    return i[1:0];
  endfunction

  function automatic logic [5:0] imm6_of(input logic [7:0] i);
    return i[5:0];
  endfunction

  // Sign-extends a 6-bit offset; callers truncate to their own address width.
  function automatic logic [SEXT_W-1:0] sext6(input logic [5:0] v);
    return {{(SEXT_W-6){v[5]}}, v};
  endfunction

endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// Instruction-memory address/data and data-memory request/ready bundle.
interface imem_fetch_ctrl_if #(
  parameter int unsigned ADDR_W = 8
);
  logic [ADDR_W-1:0] pc;
  logic [7:0]        instruction;
  logic              mem_read;
  logic              mem_write;
  logic              dmem_ready;

  modport master (
    output pc, mem_read, mem_write,
    input  instruction, dmem_ready
  );

  modport slave (
    input  pc, mem_read, mem_write,
    output instruction, dmem_ready
  );
endinterface

// File: rtl/imem_fetch_ctrl_pc_unit.sv
// Program counter register: hold, increment, or pc-relative load.
module imem_fetch_ctrl_pc_unit
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  pc_sel_e           sel,
  input  logic [ADDR_W-1:0] offset,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_inc;

  assign pc_inc = pc + ADDR_W'(1);

  // PC update; arithmetic wraps modulo 2^ADDR_W.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= '0;
    end else begin
      case (sel)
        PC_INC:  pc <= pc_inc;
        PC_REL:  pc <= pc_inc + offset;
        default: pc <= pc;
      endcase
    end
  end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Multi-cycle fetch/decode/sequence controller with timed data-memory handshake.
module imem_fetch_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned PROG_LEN    = 9,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  imem_fetch_ctrl_if.master   bus,
  output logic [7:0]          ir,
  output logic                reg_write,
  output logic [1:0]          reg_dst,
  output logic                halted,
  output logic                err,
  output logic [2:0]          state_o
);

  localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [7:0]        ir_q;
  logic              ir_load;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  pc_sel_e           pc_sel;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] jump_off;
  logic [1:0]        op;
  logic              reg_write_q, reg_write_d;
  logic [1:0]        reg_dst_q, reg_dst_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic              halted_q, halted_d;
  logic              err_q, err_d;

  assign op       = op_of(ir_q);
  assign jump_off = ADDR_W'(sext6(imm6_of(ir_q)));

  imem_fetch_ctrl_pc_unit #(.ADDR_W(ADDR_W)) u_pc (
    .clk    (clk),
    .reset  (reset),
    .sel    (pc_sel),
    .offset (jump_off),
    .pc     (pc_q)
  );

  // Next state, pc control and next values of the registered strobes.
  always_comb begin
    state_d = state_q;
    pc_sel  = PC_HOLD;
    ir_load = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (run) state_d = S_FETCH;
      S_FETCH: begin
        if (32'(pc_q) >= PROG_LEN) begin
          state_d = S_HALT;
        end else begin
          ir_load = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        case (op)
          OP_ADD:  state_d = S_WB;
          OP_JUMP: begin
            pc_sel  = PC_REL;
            state_d = run ? S_FETCH : S_IDLE;
          end
          default: state_d = S_MEM;
        endcase
      end
      S_MEM: begin
        if (bus.dmem_ready) begin
          cnt_d = '0;
          if (op == OP_LOAD) begin
            state_d = S_WB;
          end else begin
            pc_sel  = PC_INC;
            state_d = run ? S_FETCH : S_IDLE;
          end
        end else if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
          cnt_d   = CNT_W'(MEM_TIMEOUT);
          state_d = S_ERROR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WB: begin
        pc_sel  = PC_INC;
        state_d = run ? S_FETCH : S_IDLE;
      end
      default: state_d = state_q;
    endcase

    // Strobes are derived from the state being entered so they line up with it.
    reg_write_d = (state_d == S_WB);
    reg_dst_d   = reg_write_d ? ((op == OP_ADD) ? f_of(ir_q) : rt_of(ir_q)) : 2'b00;
    mem_read_d  = (state_d == S_MEM) && (op == OP_LOAD);
    mem_write_d = (state_d == S_MEM) && (op == OP_STORE);
    halted_d    = halted_q | (state_d == S_HALT);
    err_d       = err_q | (state_d == S_ERROR);
  end

  // State, instruction register, wait counter and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ir_q        <= '0;
      cnt_q       <= '0;
      reg_write_q <= 1'b0;
      reg_dst_q   <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      halted_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      reg_write_q <= reg_write_d;
      reg_dst_q   <= reg_dst_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      halted_q    <= halted_d;
      err_q       <= err_d;
      if (ir_load) ir_q <= bus.instruction;
    end
  end

  assign bus.pc        = pc_q;
  assign bus.mem_read  = mem_read_q;
  assign bus.mem_write = mem_write_q;
  assign ir            = ir_q;
  assign reg_write     = reg_write_q;
  assign reg_dst       = reg_dst_q;
  assign halted        = halted_q;
  assign err           = err_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl: vector table plus multi-cycle corner sequences.
module tb_imem_fetch_ctrl;

  localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXEC = 3'd3,
                         MEM = 3'd4, WB = 3'd5, HALT = 3'd6, ERROR = 3'd7;

  typedef struct packed {
    logic [7:0] pc;
    logic [7:0] ir;
    logic [2:0] st;
    logic       rw;
    logic [1:0] dst;
    logic       mr;
    logic       mw;
    logic       h;
    logic       e;
  } out_t;

  typedef struct {
    logic rst;
    logic run;
    logic rdy;
    out_t exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic [7:0] ir;
  logic       reg_write;
  logic [1:0] reg_dst;
  logic       halted;
  logic       err;
  logic [2:0] state_o;
  logic [7:0] imem [256];
  out_t       act;
  vec_t       tbl [16];
  int         n_vec = 0;
  int         n_bad = 0;

  imem_fetch_ctrl_if #(.ADDR_W(8)) bus ();

  imem_fetch_ctrl #(.ADDR_W(8), .PROG_LEN(9), .MEM_TIMEOUT(15)) dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .bus       (bus),
    .ir        (ir),
    .reg_write (reg_write),
    .reg_dst   (reg_dst),
    .halted    (halted),
    .err       (err),
    .state_o   (state_o)
  );

  always #5 clk = ~clk;

  assign bus.instruction = imem[bus.pc];
  assign act = {bus.pc, ir, state_o, reg_write, reg_dst, bus.mem_read, bus.mem_write, halted, err};

  function automatic out_t mk(input logic [7:0] pc, input logic [7:0] irv, input logic [2:0] st,
                              input logic rw, input logic [1:0] dst, input logic mr, input logic mw,
                              input logic h, input logic e);
    return {pc, irv, st, rw, dst, mr, mw, h, e};
  endfunction

  // Drive inputs, let one rising edge pass, then compare all outputs.
  task automatic step(input logic rst, input logic r, input logic rdy, input out_t exp, input string name);
    reset          = rst;
    run            = r;
    bus.dmem_ready = rdy;
    @(posedge clk);
    #1;
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got pc=%0d ir=%h st=%0d rw=%b dst=%0d mr=%b mw=%b h=%b e=%b; want pc=%0d ir=%h st=%0d rw=%b dst=%0d mr=%b mw=%b h=%b e=%b",
               name, act.pc, act.ir, act.st, act.rw, act.dst, act.mr, act.mw, act.h, act.e,
               exp.pc, exp.ir, exp.st, exp.rw, exp.dst, exp.mr, exp.mw, exp.h, exp.e);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) imem[i] = 8'h00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    run = 1'b0;
    bus.dmem_ready = 1'b0;
    clear_mem();

    // ADD rd0, STORE, ADD rd3 with run dropped during its EXEC, then restart.
    imem[0] = 8'h00;
    imem[1] = 8'hB1;
    imem[2] = 8'h1B;
    tbl[0]  = '{1'b1, 1'b0, 1'b0, mk(8'd0, 8'h00, IDLE,   1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0)};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, mk(8'd0, 8'h00, FETCH,  1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0)};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, mk(8'd0, 8'h00, DECODE, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0)};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, mk(8'd0, 8'h00, EXEC,   1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0)};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, mk(8'd0, 8'h00, WB,     1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0)};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, mk(8'd1, 8'h00, FETCH,  1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0)};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, mk(8'd1, 8'hB1, DECODE, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0)};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, mk(8'd1, 8'hB1, EXEC,   1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0)};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, mk(8'd1, 8'hB1, MEM,    1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0)};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, mk(8'd2, 8'hB1, FETCH,  1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0)};
    tbl[10] = '{1'b0, 1'b1, 1'b0, mk(8'd2, 8'h1B, DECODE, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0)};
    tbl[11] = '{1'b0, 1'b0, 1'b0, mk(8'd2, 8'h1B, EXEC,   1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0)};
    tbl[12] = '{1'b0, 1'b0, 1'b0, mk(8'd2, 8'h1B, WB,     1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0)};
    tbl[13] = '{1'b0, 1'b0, 1'b0, mk(8'd3, 8'h1B, IDLE,   1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0)};
    tbl[14] = '{1'b0, 1'b0, 1'b1, mk(8'd3, 8'h1B, IDLE,   1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0)};
    tbl[15] = '{1'b0, 1'b1, 1'b0, mk(8'd3, 8'h1B, FETCH,  1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0)};
    for (int i = 0; i < 16; i++)
      step(tbl[i].rst, tbl[i].run, tbl[i].rdy, tbl[i].exp, $sformatf("tbl%0d", i));

    // LOAD rt=2 with ready on the third MEM cycle.
    clear_mem();
    imem[0] = 8'h69;
    step(1'b1, 1'b0, 1'b0, mk(8'd0, 8'h00, IDLE,   1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0), "ld_reset");
    step(1'b0, 1'b1, 1'b0, mk(8'd0, 8'h00, FETCH,  1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0), "ld_fetch");
    step(1'b0, 1'b1, 1'b0, mk(8'd0, 8'h69, DECODE, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0), "ld_decode");
    step(1'b0, 1'b1, 1'b0, mk(8'd0, 8'h69, EXEC,   1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0), "ld_exec");
    step(1'b0, 1'b1, 1'b0, mk(8'd0, 8'h69, MEM,    1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0), "ld_mem1");
    step(1'b0, 1'b1, 1'b0, mk(8'd0, 8'h69, MEM,    1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0), "ld_mem2");
    step(1'b0, 1'b1, 1'b0, mk(8'd0, 8'h69, MEM,    1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0), "ld_mem3");
    step(1'b0, 1'b1, 1'b1, mk(8'd0, 8'h69, WB,     1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0), "ld_wb");
    step(1'b0, 1'b1, 1'b0, mk(8'd1, 8'h69, FETCH,  1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0), "ld_next");

    // LOAD that never sees ready: 15 MEM cycles, then sticky ERROR.
    step(1'b1, 1'b0, 1'b0, mk(8'd0, 8'h00, IDLE,   1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0), "to_reset");
    step(1'b0, 1'b1, 1'b0, mk(8'd0, 8'h00, FETCH,  1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0), "to_fetch");
    step(1'b0, 1'b1, 1'b0, mk(8'd0, 8'h69, DECODE, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0), "to_decode");
    step(1'b0, 1'b1, 1'b0, mk(8'd0, 8'h69, EXEC,   1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0), "to_exec");
    step(1'b0, 1'b1, 1'b0, mk(8'd0, 8'h69, MEM,    1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0), "to_mem1");
    for (int k = 2; k <= 15; k++)
      step(1'b0, 1'b1, 1'b0, mk(8'd0, 8'h69, MEM, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0), $sformatf("to_mem%0d", k));
    step(1'b0, 1'b1, 1'b0, mk(8'd0, 8'h69, ERROR,  1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1), "to_error");
    step(1'b0, 1'b1, 1'b1, mk(8'd0, 8'h69, ERROR,  1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1), "to_sticky");

    // Reset arriving in the middle of a LOAD handshake at pc=1.
    clear_mem();
    imem[1] = 8'h69;
    step(1'b1, 1'b0, 1'b0, mk(8'd0, 8'h00, IDLE,   1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0), "rm_reset");
    step(1'b0, 1'b1, 1'b0, mk(8'd0, 8'h00, FETCH,  1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0), "rm_f0");
    step(1'b0, 1'b1, 1'b0, mk(8'd0, 8'h00, DECODE, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0), "rm_d0");
    step(1'b0, 1'b1, 1'b0, mk(8'd0, 8'h00, EXEC,   1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0), "rm_e0");
    step(1'b0, 1'b1, 1'b0, mk(8'd0, 8'h00, WB,     1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0), "rm_w0");
    step(1'b0, 1'b1, 1'b0, mk(8'd1, 8'h00, FETCH,  1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0), "rm_f1");
    step(1'b0, 1'b1, 1'b0, mk(8'd1, 8'h69, DECODE, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0), "rm_d1");
    step(1'b0, 1'b1, 1'b0, mk(8'd1, 8'h69, EXEC,   1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0), "rm_e1");
    step(1'b0, 1'b1, 1'b0, mk(8'd1, 8'h69, MEM,    1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0), "rm_m1");
    step(1'b0, 1'b1, 1'b0, mk(8'd1, 8'h69, MEM,    1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0), "rm_m2");
    step(1'b1, 1'b1, 1'b0, mk(8'd0, 8'h00, IDLE,   1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0), "rm_mid_reset");
    step(1'b0, 1'b1, 1'b0, mk(8'd0, 8'h00, FETCH,  1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0), "rm_restart");

    // JUMP +7 to pc=8, JUMP -2 back to 7, then run off the end at pc=9.
    clear_mem();
    imem[0] = 8'hC7;
    imem[7] = 8'h00;
    imem[8] = 8'hFE;
    step(1'b1, 1'b0, 1'b0, mk(8'd0, 8'h00, IDLE,   1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0), "jp_reset");
    step(1'b0, 1'b1, 1'b0, mk(8'd0, 8'h00, FETCH,  1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0), "jp_f0");
    step(1'b0, 1'b1, 1'b0, mk(8'd0, 8'hC7, DECODE, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0), "jp_d0");
    step(1'b0, 1'b1, 1'b0, mk(8'd0, 8'hC7, EXEC,   1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0), "jp_e0");
    step(1'b0, 1'b1, 1'b0, mk(8'd8, 8'hC7, FETCH,  1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0), "jp_fwd");
    step(1'b0, 1'b1, 1'b0, mk(8'd8, 8'hFE, DECODE, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0), "jp_d8");
    step(1'b0, 1'b1, 1'b0, mk(8'd8, 8'hFE, EXEC,   1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0), "jp_e8");
    step(1'b0, 1'b1, 1'b0, mk(8'd7, 8'hFE, FETCH,  1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0), "jp_back");
    imem[8] = 8'h00;
    step(1'b0, 1'b1, 1'b0, mk(8'd7, 8'h00, DECODE, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0), "jp_d7");
    step(1'b0, 1'b1, 1'b0, mk(8'd7, 8'h00, EXEC,   1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0), "jp_e7");
    step(1'b0, 1'b1, 1'b0, mk(8'd7, 8'h00, WB,     1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0), "jp_w7");
    step(1'b0, 1'b1, 1'b0, mk(8'd8, 8'h00, FETCH,  1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0), "jp_f8");
    step(1'b0, 1'b1, 1'b0, mk(8'd8, 8'h00, DECODE, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0), "jp_d8b");
    step(1'b0, 1'b1, 1'b0, mk(8'd8, 8'h00, EXEC,   1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0), "jp_e8b");
    step(1'b0, 1'b1, 1'b0, mk(8'd8, 8'h00, WB,     1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0), "jp_w8");
    step(1'b0, 1'b1, 1'b0, mk(8'd9, 8'h00, FETCH,  1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0), "jp_f9");
    step(1'b0, 1'b1, 1'b0, mk(8'd9, 8'h00, HALT,   1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0), "jp_halt");
    step(1'b0, 1'b1, 1'b1, mk(8'd9, 8'h00, HALT,   1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0), "jp_frozen1");
    step(1'b0, 1'b0, 1'b0, mk(8'd9, 8'h00, HALT,   1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0), "jp_frozen2");
    step(1'b1, 1'b0, 1'b0, mk(8'd0, 8'h00, IDLE,   1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0), "jp_unhalt");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
Multi-cycle fetch/decode/sequence controller for the 8-bit core. It owns the program counter and drives the instruction-memory address. It latches the fetched byte into an instruction register and steps a per-instruction state machine that emits register-file and data-memory control strobes. Data-memory accesses use a valid/ready handshake with a timeout.

Parameters:
ADDR_W, 8, width of PC and instruction-memory address
PROG_LEN, 9, number of valid instruction words; a fetch at pc >= PROG_LEN halts
MEM_TIMEOUT, 15, max cycles to wait for dmem_ready before entering ERROR

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
run  in  1  1 = execute; 0 = stop at next instruction boundary
instruction  in  8  combinational data from instruction memory at pc
pc  out  ADDR_W  instruction-memory address (program counter)
ir  out  8  latched instruction register
reg_write  out  1  register-file write strobe, 1 cycle
reg_dst  out  2  destination register index
mem_read  out  1  data-memory read request, held until ready
mem_write  out  1  data-memory write request, held until ready
dmem_ready  in  1  data-memory completion for current request
halted  out  1  sticky; program ran off end
err  out  1  sticky; data-memory timeout
state_o  out  3  current state encoding, for debug

Behaviour:
- Reset (sync, high): pc=0, ir=0, all strobes=0, halted=0, err=0, state=IDLE, wait counter=0. Reset overrides every state, including mid-MEM handshake.
- ISA fields in ir:
  - op=ir[7:6], rs=ir[5:4], rt=ir[3:2], f=ir[1:0].
  - 00 ADD: rd=f, rd=rs+rt.
  - 01 LOAD: rt=Mem[rs+sext(f)].
  - 10 STORE: Mem[rs+sext(f)]=rt.
  - 11 JUMP: pc = pc + 1 + sext(ir[5:0]), mod 2^ADDR_W.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, ERROR.
- IDLE: all strobes 0. Go to FETCH when run=1.
- FETCH:
  - If pc >= PROG_LEN: go to HALT and set halted=1.
  - Else latch ir<=instruction and go to DECODE.
- DECODE: 1 cycle, no strobes. Go to EXEC.
- EXEC:
  - ADD -> WB.
  - LOAD/STORE -> MEM.
  - JUMP: load pc with the target, then return to FETCH (or IDLE if run=0).
- MEM:
  - Assert mem_read (LOAD) or mem_write (STORE) every cycle in MEM. Never both.
  - The wait counter increments each MEM cycle without dmem_ready.
  - dmem_ready=1 in MEM: deassert the strobe next cycle and clear the counter. LOAD -> WB. STORE: pc<=pc+1, then FETCH/IDLE.
  - Counter reaching MEM_TIMEOUT with no ready: go to ERROR, err=1.
- WB:
  - reg_write=1 for exactly this cycle.
  - reg_dst=f for ADD, rt for LOAD. reg_dst holds 0 when reg_write=0.
  - pc<=pc+1, then FETCH/IDLE.
- Instruction-boundary rule: run is sampled only at the end of the final state of an instruction. run=0 there -> IDLE with pc already advanced. run never aborts an instruction.
- Latency (ready on first MEM cycle): ADD 4 cycles, LOAD 5, STORE 4, JUMP 3. Each wait cycle adds 1.
- PC arithmetic is modulo 2^ADDR_W. Wrap from 255 to 0 is legal, but PROG_LEN normally halts first.
- HALT and ERROR are terminal until reset. All strobes are 0 in both, and pc is frozen.
- dmem_ready outside MEM is ignored.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared package cpu_pkg:
  - opcode constants OP_ADD=2'b00, OP_LOAD=2'b01, OP_STORE=2'b10, OP_JUMP=2'b11.
  - state enum/encodings for the eight states.
  - field-slice helpers for rs/rt/f/imm6.
  - sign-extend function.
- One natural sub-module, pc_unit: PC register with hold/increment/relative-load select.
- The FSM stays in imem_fetch_ctrl.

Test Plan:
- ADD: program [0]=8'h00, run=1, dmem_ready=0 -> FETCH/DECODE/EXEC/WB, reg_write pulses in cycle 4 with reg_dst=0, pc 0->1.
- LOAD with 2 wait states: ir=8'b01101001, dmem_ready high on 3rd MEM cycle -> mem_read high for exactly 3 cycles, then WB with reg_dst=2, pc+1, 7 cycles total.
- STORE: ir=8'b10110001, ready on first MEM cycle -> mem_write 1 cycle, reg_write never asserted, pc+1 after 4 cycles.
- JUMP back: pc=8, ir=8'b11111110 (offset -2) -> pc=7 after EXEC, no strobes. Then pc stepped to PROG_LEN=9 -> halted=1, state HALT, pc frozen at 9.
- Timeout, then reset mid-MEM:
  - LOAD with dmem_ready held 0 -> err=1 after 15 MEM cycles, mem_read drops, state ERROR.
  - Separately, reset asserted during MEM -> next cycle pc=0, mem_read=0, state IDLE.
- run dropped during EXEC of an ADD -> instruction completes (WB reg_write pulse), pc=1, state IDLE. run reasserted -> FETCH at pc=1.
